ps2_keyboard_ascii: RTL and testbench
=====================================

Name: ps2_keyboard_ascii

Overview:
Upstream stage of user_input. Receives PS/2 Set-2 scan-code frames from the keyboard, validates them, tracks break (F0) and extended (E0) prefixes, and translates make codes into the one-cycle ASCII strobe that user_input consumes on ascii_code. Between keys, ascii_code idles at 8'h2A ('*'), which user_input treats as "no key".

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles with no PS/2 falling edge mid-frame before the frame is aborted (1 ms at 100 MHz).
IDLE_CODE, 8'h2A, value driven on ascii_code when no key strobe is active.

Ports:
clk  input  1  system clock, all logic on posedge.
reset  input  1  asynchronous, active-high reset.
ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
ascii_code  output  8  translated key for one cycle, otherwise IDLE_CODE.
ascii_valid  output  1  high for exactly the cycle ascii_code carries a key.
frame_error  output  1  one-cycle pulse on a parity, start or stop error, or on timeout.

Behaviour:
- Reset values: ascii_code=IDLE_CODE, ascii_valid=0, frame_error=0. State=IDLE, prefix flags cleared, bit counter=0, timeout counter=0, synchronisers=1.
- Synchronisers: 2-FF synchroniser on ps2_clk and on ps2_data.
- Edge detect: a falling edge is synced-clk 1 then 0. All bits are sampled from synced data on that cycle.
- FSM IDLE:
  - On a falling edge with data=0 (start bit), go to RECV and set bitcnt=0.
  - On a falling edge with data=1, stay in IDLE and pulse frame_error.
- FSM RECV:
  - Shift in 8 data bits LSB first, then the parity bit, then the stop bit (bitcnt 0..9).
  - The falling edge carrying the stop bit moves to CHECK.
- FSM CHECK: one cycle, then IDLE.
  - Frame is valid only if odd parity holds over data+parity and stop=1.
  - If invalid: pulse frame_error and clear both prefix flags.
- Timeout:
  - The counter resets on every falling edge and counts only while in RECV.
  - Reaching TIMEOUT_CYCLES-1: go to IDLE, pulse frame_error, clear prefix flags, discard partial bits.
- Prefix handling on a valid byte:
  - F0 sets brk.
  - E0 sets ext.
  - Any other byte is a "final" byte: it is translated only if brk=0, and always clears both brk and ext.
  - Sequences E0 F0 xx, or F0 alone before an error, emit nothing.
- Translation (final byte, no brk):
  - Digits: 45→30, 16→31, 1E→32, 26→33, 25→34, 2E→35, 36→36, 3D→37, 3E→38, 46→39.
  - Letters: 15→71 'q', 32→62 'b', 21→63 'c', 1D→77 'w', 2C→74 't'.
  - 5A→0D Enter, with or without ext (keypad Enter).
  - 7C→2A keypad '*', only with ext=0.
  - Any other code, or ext=1 for anything except 5A: no strobe.
- Latency: stop-bit edge detected in cycle E; CHECK in E+1; ascii_code/ascii_valid registered, high in E+2 only. Returns to IDLE_CODE/0 in E+3.
- No back-pressure: the consumer samples each cycle. Keystrokes arrive ≥~1 ms apart, so no buffering is required.
- Reset mid-frame: immediate return to the reset state; the partial frame is lost; the keyboard's next frame decodes normally.

Optional Feature:
PS2_REPEAT_FILTER_EN
- Defined: a held-key register stores the last translated make code (valid bit + scan code).
  - A repeated make of the same code (typematic) with no intervening break emits no strobe.
  - The break of that code (F0 xx) clears the register.
  - A different key's make emits normally and replaces the register.
  - Reset and timeout clear the register.
- Not defined: every valid make code emits a strobe, including typematic repeats.

Test Plan:
- Reset asserted mid-frame (after 4 bits), then a clean frame 0x16 → no strobe before reset; after reset, ascii_code=0x31 with ascii_valid for 1 cycle at E+2; otherwise 0x2A.
- Frames 0x15, F0 15 → one strobe 0x71, none for the break sequence; frame_error stays 0.
- Frame 0x5A with bad parity → frame_error pulse at E+2, no strobe. Next frame E0 5A → strobe 0x0D.
- Start 0x3E frame, stop toggling ps2_clk after 5 bits for > TIMEOUT_CYCLES → frame_error pulse, FSM in IDLE. Next frame 0x45 → strobe 0x30.
- Frames 0x2C, 0x2C, F0 2C, 0x2C → strobes 0x74, 0x74, 0x74. With PS2_REPEAT_FILTER_EN: 0x74, none, 0x74.
- Unmapped 0x1C and E0 7C → no strobe, no frame_error, ascii_code constant 0x2A.

Source files
------------

// File: rtl/ps2_keyboard_ascii.sv
// PS/2 Set-2 keyboard receiver: frame capture, F0/E0 prefix tracking and scan-code to ASCII strobe.
// Optional macro PS2_REPEAT_FILTER_EN suppresses typematic repeats of the currently held key.
module ps2_keyboard_ascii #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  IDLE_CODE      = 8'h2A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ascii_code,
    output logic       ascii_valid,
    output logic       frame_error
);

    localparam int             TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    logic          ps2c_s1_q, ps2c_s2_q, ps2c_s3_q;
    logic          ps2d_s1_q, ps2d_s2_q;
    logic          fall;
    logic          data_bit;

    state_t        state_q, state_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [9:0]    shift_q, shift_d;
    logic          brk_q, brk_d;
    logic          ext_q, ext_d;
    logic [7:0]    ascii_q, ascii_d;
    logic          vld_q, vld_d;
    logic          err_q, err_d;
`ifdef PS2_REPEAT_FILTER_EN
    logic          held_vld_q, held_vld_d;
    logic [7:0]    held_code_q, held_code_d;
`endif

    logic [7:0]    rx_byte;
    logic          frame_ok;
    logic [8:0]    xl;

    // Returns {hit, ascii}; extended codes only translate keypad Enter.
    function automatic logic [8:0] xlate(input logic [7:0] sc, input logic ext);
        logic [8:0] r;
        r = 9'h000;
        if (ext) begin
            if (sc == 8'h5A) r = {1'b1, 8'h0D};
        end else begin
            case (sc)
                8'h45: r = {1'b1, 8'h30};
                8'h16: r = {1'b1, 8'h31};
                8'h1E: r = {1'b1, 8'h32};
                8'h26: r = {1'b1, 8'h33};
                8'h25: r = {1'b1, 8'h34};
                8'h2E: r = {1'b1, 8'h35};
                8'h36: r = {1'b1, 8'h36};
                8'h3D: r = {1'b1, 8'h37};
                8'h3E: r = {1'b1, 8'h38};
                8'h46: r = {1'b1, 8'h39};
                8'h15: r = {1'b1, 8'h71};
                8'h32: r = {1'b1, 8'h62};
                8'h21: r = {1'b1, 8'h63};
                8'h1D: r = {1'b1, 8'h77};
                8'h2C: r = {1'b1, 8'h74};
                8'h5A: r = {1'b1, 8'h0D};
                8'h7C: r = {1'b1, 8'h2A};
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2c_s1_q <= 1'b1;
            ps2c_s2_q <= 1'b1;
            ps2c_s3_q <= 1'b1;
            ps2d_s1_q <= 1'b1;
            ps2d_s2_q <= 1'b1;
        end else begin
            ps2c_s1_q <= ps2_clk;
            ps2c_s2_q <= ps2c_s1_q;
            ps2c_s3_q <= ps2c_s2_q;
            ps2d_s1_q <= ps2_data;
            ps2d_s2_q <= ps2d_s1_q;
        end
    end

    assign fall     = ps2c_s3_q & ~ps2c_s2_q;
    assign data_bit = ps2d_s2_q;

    // After ten shifts: [7:0] data, [8] parity, [9] stop.
    assign rx_byte  = shift_q[7:0];
    assign frame_ok = (^shift_q[8:0]) & shift_q[9];
    assign xl       = xlate(rx_byte, ext_q);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        tcnt_d   = tcnt_q;
        shift_d  = shift_q;
        brk_d    = brk_q;
        ext_d    = ext_q;
        ascii_d  = IDLE_CODE;
        vld_d    = 1'b0;
        err_d    = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
        held_vld_d  = held_vld_q;
        held_code_d = held_code_q;
`endif
        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (fall) begin
                    if (!data_bit) begin
                        state_d  = S_RECV;
                        bitcnt_d = 4'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RECV: begin
                if (fall) begin
                    tcnt_d  = '0;
                    shift_d = {data_bit, shift_q[9:1]};
                    if (bitcnt_q == 4'd9) begin
                        state_d = S_CHECK;
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end else if (tcnt_q == TLAST) begin
                    state_d  = S_IDLE;
                    bitcnt_d = 4'd0;
                    tcnt_d   = '0;
                    err_d    = 1'b1;
                    brk_d    = 1'b0;
                    ext_d    = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
                    held_vld_d = 1'b0;
`endif
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                state_d  = S_IDLE;
                bitcnt_d = 4'd0;
                tcnt_d   = '0;
                if (!frame_ok) begin
                    err_d = 1'b1;
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end else if (rx_byte == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (rx_byte == 8'hE0) begin
                    ext_d = 1'b1;
                end else begin
                    brk_d = 1'b0;
                    ext_d = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
                    if (brk_q) begin
                        if (held_vld_q && held_code_q == rx_byte) held_vld_d = 1'b0;
                    end else if (xl[8] && !(held_vld_q && held_code_q == rx_byte)) begin
                        ascii_d     = xl[7:0];
                        vld_d       = 1'b1;
                        held_vld_d  = 1'b1;
                        held_code_d = rx_byte;
                    end
`else
                    if (!brk_q && xl[8]) begin
                        ascii_d = xl[7:0];
                        vld_d   = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d  = S_IDLE;
                bitcnt_d = 4'd0;
                tcnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bitcnt_q <= 4'd0;
            tcnt_q   <= '0;
            brk_q    <= 1'b0;
            ext_q    <= 1'b0;
            ascii_q  <= IDLE_CODE;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
            held_vld_q  <= 1'b0;
            held_code_q <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            tcnt_q   <= tcnt_d;
            brk_q    <= brk_d;
            ext_q    <= ext_d;
            ascii_q  <= ascii_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
`ifdef PS2_REPEAT_FILTER_EN
            held_vld_q  <= held_vld_d;
            held_code_q <= held_code_d;
`endif
        end
    end

    // Shift register is pure data and is only meaningful once ten bits are in.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign ascii_code  = ascii_q;
    assign ascii_valid = vld_q;
    assign frame_error = err_q;

endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// Scoreboard bench for ps2_keyboard_ascii: driver pushes expected strobes/errors, monitor pops and compares.
module tb_ps2_keyboard_ascii;

    localparam int TO   = 200;
    localparam int HALF = 10;
    localparam int GAP  = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] ascii_code;
    logic       ascii_valid;
    logic       frame_error;

    ps2_keyboard_ascii #(.TIMEOUT_CYCLES(TO), .IDLE_CODE(8'h2A)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ascii_code(ascii_code), .ascii_valid(ascii_valid), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        int         at;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    bit         m_brk, m_ext, m_held_v;
    logic [7:0] m_held;
    logic [7:0] amap [logic [7:0]];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void push_exp(bit e, logic [7:0] c, int at);
        exp_t x;
        x.is_err = e;
        x.code   = c;
        x.at     = at;
        expq.push_back(x);
    endfunction

    function automatic void model_clear(bit held_too);
        m_brk = 1'b0;
        m_ext = 1'b0;
        if (held_too) m_held_v = 1'b0;
    endfunction

    // Reference: a valid byte as the keyboard protocol defines it; strobe appears 4 clk after the stop edge is driven.
    function automatic void model_byte(logic [7:0] b, int drive_cyc);
        bit         hit;
        logic [7:0] code;
        hit  = 1'b0;
        code = 8'h00;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            if (!m_brk) begin
                if (m_ext) begin
                    if (b == 8'h5A) begin hit = 1'b1; code = 8'h0D; end
                end else if (amap.exists(b)) begin
                    hit = 1'b1; code = amap[b];
                end
            end
`ifdef PS2_REPEAT_FILTER_EN
            if (m_brk && m_held_v && m_held == b) m_held_v = 1'b0;
            if (hit && m_held_v && m_held == b) hit = 1'b0;
            else if (hit) begin m_held_v = 1'b1; m_held = b; end
`endif
            if (hit) push_exp(1'b0, code, drive_cyc + 4);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endfunction

    task automatic ps2_bit(input logic d);
        ps2_data = d;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop
    task automatic send_frame(input logic [7:0] b, input int kind);
        logic [9:0] bits;
        int         fc;
        bits = {1'b0, (~^b) ^ (kind == 1), b};
        ps2_bit(1'b0);
        for (int i = 0; i < 9; i++) ps2_bit(bits[i]);
        ps2_data = (kind != 2);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        fc = cyc;
        if (kind == 0) model_byte(b, fc);
        else begin
            push_exp(1'b1, 8'h00, fc + 4);
            model_clear(1'b0);
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_timeout(input logic [7:0] b);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(b[i]);
        ps2_data = 1'b1;
        push_exp(1'b1, 8'h00, -1);
        model_clear(1'b1);
        repeat (TO + 50) @(negedge clk);
    endtask

    task automatic start_glitch();
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        push_exp(1'b1, 8'h00, -1);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic reset_mid_frame(input logic [7:0] b);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(b[i]);
        reset = 1'b1;
        model_clear(1'b1);
        repeat (3) @(negedge clk);
        check("midreset_code", {24'h0, ascii_code}, 32'h2A);
        check("midreset_valid", {31'h0, ascii_valid}, 32'h0);
        check("midreset_err", {31'h0, frame_error}, 32'h0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    exp_t mx;
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (ascii_valid) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_strobe: actual=%0h required=none (t=%0t)", ascii_code, $time);
                end else begin
                    mx = expq.pop_front();
                    check("strobe_kind", {31'h0, mx.is_err}, 32'h0);
                    check("strobe_code", {24'h0, ascii_code}, {24'h0, mx.code});
                    if (mx.at >= 0) check("strobe_cycle", cyc, mx.at);
                end
            end
            if (frame_error) begin
                if (expq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_error: actual=1 required=0 (t=%0t)", $time);
                end else begin
                    mx = expq.pop_front();
                    check("error_kind", {31'h0, mx.is_err}, 32'h1);
                    if (mx.at >= 0) check("error_cycle", cyc, mx.at);
                end
            end
            if (!ascii_valid && ascii_code !== 8'h2A) begin
                n_cmp++; n_bad++;
                $display("FAIL idle_code: actual=%0h required=2a (t=%0t)", ascii_code, $time);
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    logic [7:0] pool [24];
    logic [7:0] last_b;
    int         r;

    initial begin
        amap[8'h45] = 8'h30; amap[8'h16] = 8'h31; amap[8'h1E] = 8'h32; amap[8'h26] = 8'h33;
        amap[8'h25] = 8'h34; amap[8'h2E] = 8'h35; amap[8'h36] = 8'h36; amap[8'h3D] = 8'h37;
        amap[8'h3E] = 8'h38; amap[8'h46] = 8'h39; amap[8'h15] = 8'h71; amap[8'h32] = 8'h62;
        amap[8'h21] = 8'h63; amap[8'h1D] = 8'h77; amap[8'h2C] = 8'h74; amap[8'h5A] = 8'h0D;
        amap[8'h7C] = 8'h2A;
        pool = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                 8'h15, 8'h32, 8'h21, 8'h1D, 8'h2C, 8'h5A, 8'h7C, 8'hF0, 8'hE0, 8'hF0,
                 8'hE0, 8'h1C, 8'h00, 8'hAA};
        model_clear(1'b1);
        m_held = 8'h00;

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_code", {24'h0, ascii_code}, 32'h2A);
        check("reset_valid", {31'h0, ascii_valid}, 32'h0);
        check("reset_err", {31'h0, frame_error}, 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        reset_mid_frame(8'h16);
        send_frame(8'h16, 0);

        send_frame(8'h15, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h15, 0);

        send_frame(8'h5A, 1);
        send_frame(8'hE0, 0);
        send_frame(8'h5A, 0);

        send_timeout(8'h3E);
        send_frame(8'h45, 0);

        send_frame(8'h2C, 0);
        send_frame(8'h2C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h2C, 0);
        send_frame(8'h2C, 0);

        send_frame(8'h1C, 0);
        send_frame(8'hE0, 0);
        send_frame(8'h7C, 0);

        start_glitch();
        send_frame(8'h3D, 2);
        send_frame(8'h3D, 0);

        last_b = 8'h16;
        for (int n = 0; n < 110; n++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       send_frame(8'($urandom_range(0, 255)), 1);
            else if (r < 8)  send_frame(8'($urandom_range(0, 255)), 2);
            else if (r < 11) send_timeout(8'($urandom_range(0, 255)));
            else if (r < 14) start_glitch();
            else begin
                if (r >= 82) send_frame(last_b, 0);
                else begin
                    last_b = pool[$urandom_range(0, 23)];
                    send_frame(last_b, 0);
                end
            end
        end

        repeat (50) @(negedge clk);
        check("queue_empty", expq.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
